// File: rtl/sram_like_arbiter.sv
// N-master to 1-slave arbiter for the SRAM-like req/addr_ok/data_ok bus, with in-order response routing.
// Latency: zero cycles; grant, addr_ok and data_ok are all combinational on the current inputs.
// Backpressure: a stalled slave locks the grant; a full ID tracker drops s_req until a response pops.
module sram_like_arbiter #(
    parameter int NUM_MASTERS     = 2,
    parameter int MAX_OUTSTANDING = 4,
    parameter int DATA_W          = 32,
    parameter int ADDR_W          = 32,
    parameter int RR_MODE         = 1
) (
    input  logic                               clk,
    input  logic                               resetn,
    input  logic [NUM_MASTERS-1:0]             m_req,
    input  logic [NUM_MASTERS-1:0]             m_wr,
    input  logic [2*NUM_MASTERS-1:0]           m_size,
    input  logic [ADDR_W*NUM_MASTERS-1:0]      m_addr,
    input  logic [(DATA_W/8)*NUM_MASTERS-1:0]  m_wstrb,
    input  logic [DATA_W*NUM_MASTERS-1:0]      m_wdata,
    output logic [NUM_MASTERS-1:0]             m_addr_ok,
    output logic [NUM_MASTERS-1:0]             m_data_ok,
    output logic [DATA_W-1:0]                  m_rdata,
    output logic                               s_req,
    output logic                               s_wr,
    output logic [1:0]                         s_size,
    output logic [ADDR_W-1:0]                  s_addr,
    output logic [DATA_W/8-1:0]                s_wstrb,
    output logic [DATA_W-1:0]                  s_wdata,
    input  logic                               s_addr_ok,
    input  logic                               s_data_ok,
    input  logic [DATA_W-1:0]                  s_rdata,
    output logic                               err_unexp
);

    localparam int IDW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int PW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW  = PW + 1;
    localparam int SW  = DATA_W / 8;

    typedef logic [IDW-1:0] id_t;

    // Tracker of accepted-but-unanswered IDs, oldest at rd_ptr
    id_t            fifo_q [MAX_OUTSTANDING];
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    id_t            rr_ptr_q, rr_ptr_d;
    logic           lock_q, lock_d;
    id_t            lock_id_q, lock_id_d;
    logic           err_q, err_d;

    id_t            grant;
    id_t            head_id;
    logic           full;
    logic           empty;
    logic           push;
    logic           pop;

    assign full    = (count_q == CW'(MAX_OUTSTANDING));
    assign empty   = (count_q == '0);
    assign s_req   = (|m_req) & ~full & resetn;
    assign push    = s_req & s_addr_ok;
    assign pop     = s_data_ok & ~empty & resetn;
    assign head_id = fifo_q[rd_ptr_q];
    assign m_rdata = s_rdata;
    assign err_unexp = err_q;

    // Grant: a held lock wins, otherwise round-robin from rr_ptr or lowest index first
    always_comb begin
        id_t  cand;
        logic found;
        grant = lock_id_q;
        found = 1'b0;
        cand  = '0;
        if (!lock_q) begin
            grant = '0;
            for (int k = 0; k < NUM_MASTERS; k++) begin
                if (RR_MODE != 0) begin
                    cand = id_t'((int'(rr_ptr_q) + k) % NUM_MASTERS);
                end else begin
                    cand = id_t'(k);
                end
                if (!found && m_req[cand]) begin
                    grant = cand;
                    found = 1'b1;
                end
            end
        end
    end

    // Steer the granted master's request fields onto the slave port
    always_comb begin
        s_wr    = 1'b0;
        s_size  = '0;
        s_addr  = '0;
        s_wstrb = '0;
        s_wdata = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant == id_t'(i)) begin
                s_wr    = m_wr[i];
                s_size  = m_size[i*2 +: 2];
                s_addr  = m_addr[i*ADDR_W +: ADDR_W];
                s_wstrb = m_wstrb[i*SW +: SW];
                s_wdata = m_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // One-hot accept to the granted master and response to the oldest issuer
    always_comb begin
        m_addr_ok = '0;
        m_data_ok = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (push && (grant == id_t'(i))) begin
                m_addr_ok[i] = 1'b1;
            end
            if (pop && (head_id == id_t'(i))) begin
                m_data_ok[i] = 1'b1;
            end
        end
    end

    // Next-state for tracker pointers, occupancy, rotation pointer, lock and error flag
    always_comb begin
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        rr_ptr_d  = rr_ptr_q;
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        err_d     = err_q | (s_data_ok & empty);
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if ((RR_MODE != 0) && push) begin
            rr_ptr_d = (grant == id_t'(NUM_MASTERS - 1)) ? '0 : grant + id_t'(1);
        end
        // A stalled request freezes the grant so the slave sees a stable request
        if (s_req && !s_addr_ok) begin
            lock_d    = 1'b1;
            lock_id_d = grant;
        end else if (s_addr_ok) begin
            lock_d    = 1'b0;
        end
    end

    // Control state with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            rr_ptr_q  <= '0;
            lock_q    <= 1'b0;
            lock_id_q <= '0;
            err_q     <= 1'b0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            rr_ptr_q  <= rr_ptr_d;
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
            err_q     <= err_d;
        end
    end

    // ID storage; contents are only meaningful between the pointers, so no reset
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= grant;
        end
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Bench for sram_like_arbiter: a round-robin and a fixed-priority instance share one stimulus.
// A queue-based reference model predicts every output each cycle; directed scenarios add fixed expectations.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_sram_like_arbiter;

    localparam int N  = 2;
    localparam int MO = 4;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int SW = DW / 8;

    logic            clk = 1'b0;
    logic            resetn;
    logic [N-1:0]    m_req, m_wr;
    logic [2*N-1:0]  m_size;
    logic [AW*N-1:0] m_addr;
    logic [SW*N-1:0] m_wstrb;
    logic [DW*N-1:0] m_wdata;
    logic            s_addr_ok, s_data_ok;
    logic [DW-1:0]   s_rdata;

    logic [N-1:0]  rr_m_addr_ok, rr_m_data_ok, fp_m_addr_ok, fp_m_data_ok;
    logic [DW-1:0] rr_m_rdata, fp_m_rdata, rr_s_wdata, fp_s_wdata;
    logic          rr_s_req, rr_s_wr, fp_s_req, fp_s_wr, rr_err, fp_err;
    logic [1:0]    rr_s_size, fp_s_size;
    logic [AW-1:0] rr_s_addr, fp_s_addr;
    logic [SW-1:0] rr_s_wstrb, fp_s_wstrb;

    always #5 clk = ~clk;

    sram_like_arbiter #(.NUM_MASTERS(N), .MAX_OUTSTANDING(MO), .DATA_W(DW), .ADDR_W(AW), .RR_MODE(1)) dut_rr (
        .clk(clk), .resetn(resetn), .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr),
        .m_wstrb(m_wstrb), .m_wdata(m_wdata), .m_addr_ok(rr_m_addr_ok), .m_data_ok(rr_m_data_ok),
        .m_rdata(rr_m_rdata), .s_req(rr_s_req), .s_wr(rr_s_wr), .s_size(rr_s_size), .s_addr(rr_s_addr),
        .s_wstrb(rr_s_wstrb), .s_wdata(rr_s_wdata), .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok),
        .s_rdata(s_rdata), .err_unexp(rr_err));

    sram_like_arbiter #(.NUM_MASTERS(N), .MAX_OUTSTANDING(MO), .DATA_W(DW), .ADDR_W(AW), .RR_MODE(0)) dut_fp (
        .clk(clk), .resetn(resetn), .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr),
        .m_wstrb(m_wstrb), .m_wdata(m_wdata), .m_addr_ok(fp_m_addr_ok), .m_data_ok(fp_m_data_ok),
        .m_rdata(fp_m_rdata), .s_req(fp_s_req), .s_wr(fp_s_wr), .s_size(fp_s_size), .s_addr(fp_s_addr),
        .s_wstrb(fp_s_wstrb), .s_wdata(fp_s_wdata), .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok),
        .s_rdata(s_rdata), .err_unexp(fp_err));

    int checks   = 0;
    int failures = 0;

    // Observed outputs, index 0 = round-robin instance, 1 = fixed-priority instance
    logic [N-1:0]  o_aok [2];
    logic [N-1:0]  o_dok [2];
    logic          o_sreq [2];
    logic          o_swr [2];
    logic          o_err [2];
    logic [1:0]    o_ssize [2];
    logic [AW-1:0] o_saddr [2];
    logic [SW-1:0] o_sstrb [2];
    logic [DW-1:0] o_swdata [2];
    logic [DW-1:0] o_rdata [2];
    int            o_cnt [2];

    // Reference model: outstanding issuer IDs in issue order, plus rotation/lock/error state
    int q_rr[$];
    int q_fp[$];
    int mrr [2];
    bit mlock [2];
    int mlid [2];
    bit merr [2];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int qsz(input int i);
        return (i == 0) ? q_rr.size() : q_fp.size();
    endfunction

    function automatic int qfront(input int i);
        return (i == 0) ? q_rr[0] : q_fp[0];
    endfunction

    function automatic int model_grant(input int i);
        if (mlock[i]) return mlid[i];
        for (int k = 0; k < N; k++) begin
            int cand;
            cand = (i == 0) ? (mrr[i] + k) % N : k;
            if (m_req[cand]) return cand;
        end
        return 0;
    endfunction

    function automatic void model_update(input int i);
        int g;
        bit sreq;
        if (!resetn) begin
            if (i == 0) q_rr.delete(); else q_fp.delete();
            mrr[i] = 0; mlock[i] = 0; mlid[i] = 0; merr[i] = 0;
            return;
        end
        g    = model_grant(i);
        sreq = (m_req != 0) && (qsz(i) < MO);
        if (s_data_ok) begin
            if (qsz(i) == 0) merr[i] = 1;
            else if (i == 0) void'(q_rr.pop_front());
            else void'(q_fp.pop_front());
        end
        if (sreq && s_addr_ok) begin
            if (i == 0) begin
                q_rr.push_back(g);
                mrr[i] = (g + 1) % N;
            end else begin
                q_fp.push_back(g);
            end
        end
        if (sreq && !s_addr_ok) begin
            mlock[i] = 1;
            mlid[i]  = g;
        end else if (s_addr_ok) begin
            mlock[i] = 0;
        end
    endfunction

    // One clock: sample and compare against the model, then advance the model at the edge
    task automatic step();
        @(negedge clk);
        o_aok[0] = rr_m_addr_ok;  o_aok[1] = fp_m_addr_ok;
        o_dok[0] = rr_m_data_ok;  o_dok[1] = fp_m_data_ok;
        o_sreq[0] = rr_s_req;     o_sreq[1] = fp_s_req;
        o_swr[0] = rr_s_wr;       o_swr[1] = fp_s_wr;
        o_ssize[0] = rr_s_size;   o_ssize[1] = fp_s_size;
        o_saddr[0] = rr_s_addr;   o_saddr[1] = fp_s_addr;
        o_sstrb[0] = rr_s_wstrb;  o_sstrb[1] = fp_s_wstrb;
        o_swdata[0] = rr_s_wdata; o_swdata[1] = fp_s_wdata;
        o_rdata[0] = rr_m_rdata;  o_rdata[1] = fp_m_rdata;
        o_err[0] = rr_err;        o_err[1] = fp_err;
        o_cnt[0] = int'(dut_rr.count_q);
        o_cnt[1] = int'(dut_fp.count_q);
        for (int i = 0; i < 2; i++) begin
            int g;
            bit sreq;
            logic [N-1:0] e_aok, e_dok;
            g     = model_grant(i);
            sreq  = resetn && (m_req != 0) && (qsz(i) < MO);
            e_aok = (sreq && s_addr_ok) ? N'(1 << g) : '0;
            e_dok = (resetn && s_data_ok && qsz(i) > 0) ? N'(1 << qfront(i)) : '0;
            check_eq($sformatf("u%0d.s_req", i), 64'(o_sreq[i]), 64'(sreq));
            if (sreq) begin
                check_eq($sformatf("u%0d.s_addr", i), 64'(o_saddr[i]), 64'(m_addr[g*AW +: AW]));
                check_eq($sformatf("u%0d.s_wr", i), 64'(o_swr[i]), 64'(m_wr[g]));
                check_eq($sformatf("u%0d.s_size", i), 64'(o_ssize[i]), 64'(m_size[g*2 +: 2]));
                check_eq($sformatf("u%0d.s_wstrb", i), 64'(o_sstrb[i]), 64'(m_wstrb[g*SW +: SW]));
                check_eq($sformatf("u%0d.s_wdata", i), 64'(o_swdata[i]), 64'(m_wdata[g*DW +: DW]));
            end
            check_eq($sformatf("u%0d.m_addr_ok", i), 64'(o_aok[i]), 64'(e_aok));
            check_eq($sformatf("u%0d.m_data_ok", i), 64'(o_dok[i]), 64'(e_dok));
            check_eq($sformatf("u%0d.m_rdata", i), 64'(o_rdata[i]), 64'(s_rdata));
            check_eq($sformatf("u%0d.err_unexp", i), 64'(o_err[i]), 64'(merr[i]));
            check_eq($sformatf("u%0d.count", i), 64'(o_cnt[i]), 64'(qsz(i)));
        end
        @(posedge clk);
        model_update(0);
        model_update(1);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        repeat (3) step();
        resetn = 1'b1;
    endtask

    initial begin
        logic [N-1:0] alt_seq [4];
        logic [DW-1:0] rd_seq [3];
        logic [N-1:0] ord_seq [3];
        alt_seq = '{2'b01, 2'b10, 2'b01, 2'b10};
        rd_seq  = '{32'h11, 32'h22, 32'h33};
        ord_seq = '{2'b01, 2'b10, 2'b01};

        resetn = 1'b0; m_req = '0; m_wr = 2'b10; m_size = 4'b1010;
        m_addr = {32'h2000_0000, 32'h1c00_0000}; m_wstrb = 8'hf3; m_wdata = {32'hbbbb_0001, 32'haaaa_0000};
        s_addr_ok = 1'b0; s_data_ok = 1'b0; s_rdata = '0;
        for (int i = 0; i < 2; i++) begin mrr[i] = 0; mlock[i] = 0; mlid[i] = 0; merr[i] = 0; end
        @(posedge clk); #1;

        // Reset with requests pending and slave ready
        m_req = 2'b11; s_addr_ok = 1'b1;
        resetn = 1'b0;
        repeat (3) begin
            step();
            check_eq("rst.s_req", 64'(o_sreq[0]), 64'd0);
            check_eq("rst.addr_ok", 64'(o_aok[0]), 64'd0);
        end
        check_eq("rst.count", 64'(o_cnt[0]), 64'd0);
        check_eq("rst.err", 64'(o_err[0]), 64'd0);
        resetn = 1'b1;

        // Both masters requesting: alternate in RR, master 0 only in fixed
        for (int k = 0; k < 4; k++) begin
            step();
            check_eq("rr.alternate", 64'(o_aok[0]), 64'(alt_seq[k]));
            check_eq("fp.master0", 64'(o_aok[1]), 64'd1);
        end
        step();
        check_eq("full.s_req", 64'(o_sreq[0]), 64'd0);
        check_eq("full.addr_ok", 64'(o_aok[0]), 64'd0);
        s_data_ok = 1'b1; s_rdata = 32'h5a5a_0001;
        step();
        check_eq("full.pop_dok", 64'(o_dok[0]), 64'd1);
        check_eq("full.pop_sreq", 64'(o_sreq[0]), 64'd0);
        s_data_ok = 1'b0;
        step();
        check_eq("full.reopen", 64'(o_sreq[0]), 64'd1);

        // Fixed priority grants master 1 only when master 0 is idle
        do_reset();
        m_req = 2'b10;
        step();
        check_eq("fp.master1", 64'(o_aok[1]), 64'd2);

        // Lock: rr_ptr points at master 1 but a stalled master 0 keeps the grant
        do_reset();
        m_req = 2'b01; s_addr_ok = 1'b1;
        step();
        s_addr_ok = 1'b0;
        step();
        m_req = 2'b11;
        repeat (3) begin
            step();
            check_eq("lock.s_addr", 64'(o_saddr[0]), 64'h1c00_0000);
        end
        s_addr_ok = 1'b1;
        step();
        check_eq("lock.accept", 64'(o_aok[0]), 64'd1);
        step();
        check_eq("lock.release", 64'(o_aok[0]), 64'd2);

        // In-order response routing, then an unexpected response
        do_reset();
        s_addr_ok = 1'b1;
        m_req = 2'b01; step();
        m_req = 2'b10; step();
        m_req = 2'b01; step();
        m_req = 2'b00; s_data_ok = 1'b1;
        for (int k = 0; k < 3; k++) begin
            s_rdata = rd_seq[k];
            step();
            check_eq("ord.data_ok", 64'(o_dok[0]), 64'(ord_seq[k]));
            check_eq("ord.rdata", 64'(o_rdata[0]), 64'(rd_seq[k]));
        end
        check_eq("ord.no_err", 64'(o_err[0]), 64'd0);
        step();
        check_eq("ord.extra_dok", 64'(o_dok[0]), 64'd0);
        s_data_ok = 1'b0;
        step();
        check_eq("ord.err_set", 64'(o_err[0]), 64'd1);
        step();
        check_eq("ord.err_sticky", 64'(o_err[0]), 64'd1);

        // Randomized traffic including occasional mid-transaction resets
        do_reset();
        for (int c = 0; c < 600; c++) begin
            m_req     = N'($urandom_range(0, 3));
            m_wr      = N'($urandom_range(0, 3));
            m_size    = 4'($urandom_range(0, 15));
            m_addr    = {$urandom, $urandom};
            m_wstrb   = 8'($urandom);
            m_wdata   = {$urandom, $urandom};
            s_addr_ok = ($urandom_range(0, 3) != 0);
            s_data_ok = ($urandom_range(0, 2) == 0);
            s_rdata   = $urandom;
            resetn    = ($urandom_range(0, 79) != 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
